svm_coef_loader: RTL and testbench

// Streams SVM model coefficients in one COEF_W word per beat (valid/ready) and packs
// N_COEF words into one RAM_DW row. Writes N_ROW rows into the coefficient RAM of the

---
 rtl/svm_coef_loader_if.sv | 13 +
 rtl/svm_coef_loader.sv | 125 ++++++++++++
 tb/tb_svm_coef_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_coef_loader_if.sv
// Coefficient stream channel into svm_coef_loader: one COEF_W word per beat,
// valid/ready handshake, s_last flags the closing bias word.
interface svm_coef_loader_if #(
    parameter int COEF_W = 20
);
    logic              s_valid;
    logic [COEF_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/svm_coef_loader.sv
// Packs streamed SVM coefficients into RAM rows for the selected model bank,
// then loads that bank's bias; aborts on framing errors.
module svm_coef_loader #(
    parameter int COEF_W  = 20,
    parameter int N_COEF  = 105,
    parameter int N_ROW   = 36,
    parameter int N_MODEL = 2,
    localparam int MSEL_W = (N_MODEL > 1) ? $clog2(N_MODEL) : 1,
    localparam int ADDR_W = (N_ROW > 1) ? $clog2(N_ROW) : 1,
    localparam int RAM_DW = COEF_W * N_COEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MSEL_W-1:0] model_sel,
    svm_coef_loader_if.slave  s,
    output logic [MSEL_W-1:0] bank_sel,
    output logic [ADDR_W-1:0] addr_a,
    output logic              write_en,
    output logic [RAM_DW-1:0] i_data_a,
    output logic [COEF_W-1:0] bias,
    output logic              b_load,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;

    typedef enum logic [2:0] {IDLE, FILL, WRITE, BIAS, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  row_cnt;
    logic [CNT_W-1:0]   coef_cnt;
    logic               ready_q;

    // Ready is a pure function of state, registered, so s_valid never reaches it.
    assign s.s_ready = ready_q;
    assign addr_a    = row_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the partial row register is reset too, so a reset mid-load
            // can never leak stale words into the next load's first row.
            state    <= IDLE;
            row_cnt  <= '0;
            coef_cnt <= '0;
            ready_q  <= 1'b0;
            bank_sel <= '0;
            write_en <= 1'b0;
            i_data_a <= '0;
            bias     <= '0;
            b_load   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignments; the strobes below
            // default low and are raised for exactly one cycle by the case.
            write_en <= 1'b0;
            b_load   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bank_sel <= model_sel;
                        row_cnt  <= '0;
                        coef_cnt <= '0;
                        i_data_a <= '0;
                        busy     <= 1'b1;
                        ready_q  <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (s.s_valid && ready_q) begin
                        if (s.s_last) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            ready_q <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            i_data_a[int'(coef_cnt)*COEF_W +: COEF_W] <= s.s_data;
                            if (coef_cnt == CNT_W'(N_COEF - 1)) begin
                                coef_cnt <= '0;
                                write_en <= 1'b1;
                                ready_q  <= 1'b0;
                                state    <= WRITE;
                            end else begin
                                coef_cnt <= coef_cnt + 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    // write_en is high this cycle with addr_a = current row.
                    ready_q <= 1'b1;
                    if (row_cnt == ADDR_W'(N_ROW - 1)) begin
                        state <= BIAS;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                        state   <= FILL;
                    end
                end
                BIAS: begin
                    if (s.s_valid && ready_q) begin
                        ready_q <= 1'b0;
                        busy    <= 1'b0;
                        if (s.s_last) begin
                            bias   <= s.s_data;
                            b_load <= 1'b1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_svm_coef_loader.sv
// Scoreboard bench: a small instance for framing/reset scenarios and a
// default-parameter instance for a full-size load.
module tb_svm_coef_loader;
    localparam int CW_A = 8,  NC_A = 3,   NR_A = 2;
    localparam int CW_B = 20, NC_B = 105, NR_B = 36;
    localparam int DW_B = CW_B * NC_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [5:0]      addr;
        logic [DW_B-1:0] row;
        logic            bank;
    } wr_t;

    // ---------------- small instance ----------------
    logic            rst_a, start_a, we_a, bl_a, busy_a, done_a, err_a;
    logic [0:0]      msel_a, bank_a, addr_a;
    logic [23:0]     row_a;
    logic [7:0]      bias_a;
    svm_coef_loader_if #(.COEF_W(CW_A)) if_a ();

    svm_coef_loader #(.COEF_W(CW_A), .N_COEF(NC_A), .N_ROW(NR_A), .N_MODEL(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .model_sel(msel_a), .s(if_a.slave),
        .bank_sel(bank_a), .addr_a(addr_a), .write_en(we_a), .i_data_a(row_a),
        .bias(bias_a), .b_load(bl_a), .busy(busy_a), .done(done_a), .err(err_a));

    // ---------------- default instance ----------------
    logic            rst_b, start_b, we_b, bl_b, busy_b, done_b, err_b;
    logic [0:0]      msel_b, bank_b;
    logic [5:0]      addr_b;
    logic [DW_B-1:0] row_b;
    logic [19:0]     bias_b;
    svm_coef_loader_if #(.COEF_W(CW_B)) if_b ();

    svm_coef_loader dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .model_sel(msel_b), .s(if_b.slave),
        .bank_sel(bank_b), .addr_a(addr_b), .write_en(we_b), .i_data_a(row_b),
        .bias(bias_b), .b_load(bl_b), .busy(busy_b), .done(done_b), .err(err_b));

    // Scoreboards and driver-side model state
    wr_t         wq_a[$], wq_b[$];
    logic [19:0] bq_a[$], bq_b[$];
    int          m_bidx_a, m_bidx_b, acc_b;
    logic [23:0] m_row_a;
    logic [DW_B-1:0] m_row_b;
    logic        m_bank_a, m_bank_b;
    int          exp_we_a = 0, exp_bl_a = 0, exp_err_a = 0;
    int          n_we_a = 0, n_bl_a = 0, n_err_a = 0, n_done_a = 0;
    int          n_we_b = 0, n_bl_b = 0, n_err_b = 0, n_done_b = 0;

    task automatic send_a(input logic [7:0] d, input logic last, input int gap);
        logic rdy;
        int   t;
        while (int'($urandom_range(99)) < gap) begin
            @(posedge clk); #1;
        end
        if_a.s_valid = 1'b1; if_a.s_data = d; if_a.s_last = last;
        rdy = 1'b0; t = 0;
        while (!rdy && t < 100) begin
            @(negedge clk); rdy = if_a.s_ready;
            @(posedge clk); #1; t++;
        end
        if_a.s_valid = 1'b0;
        if (!rdy) begin
            check("a_accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (m_bidx_a < NR_A * NC_A) begin
            if (last) exp_err_a++;
            else begin
                m_row_a[(m_bidx_a % NC_A)*CW_A +: CW_A] = d;
                if (m_bidx_a % NC_A == NC_A - 1) begin
                    wq_a.push_back('{addr: 6'(m_bidx_a / NC_A), row: DW_B'(m_row_a), bank: m_bank_a});
                    exp_we_a++;
                end
            end
        end else if (last) begin
            bq_a.push_back(20'(d));
            exp_bl_a++;
        end else exp_err_a++;
        m_bidx_a++;
    endtask

    task automatic send_b(input logic [19:0] d, input logic last);
        logic rdy;
        int   t;
        if_b.s_valid = 1'b1; if_b.s_data = d; if_b.s_last = last;
        rdy = 1'b0; t = 0;
        while (!rdy && t < 100) begin
            @(negedge clk); rdy = if_b.s_ready;
            @(posedge clk); #1; t++;
        end
        if_b.s_valid = 1'b0;
        if (!rdy) begin
            check("b_accept_timeout", 32'd0, 32'd1);
            return;
        end
        acc_b++;
        if (m_bidx_b < NR_B * NC_B) begin
            m_row_b[(m_bidx_b % NC_B)*CW_B +: CW_B] = d;
            if (m_bidx_b % NC_B == NC_B - 1)
                wq_b.push_back('{addr: 6'(m_bidx_b / NC_B), row: m_row_b, bank: m_bank_b});
        end else if (last) bq_b.push_back(d);
        m_bidx_b++;
    endtask

    task automatic pulse_start_a(input logic sel, input logic real_start);
        start_a = 1'b1; msel_a = sel;
        @(posedge clk); #1;
        start_a = 1'b0;
        if (real_start) begin
            m_bidx_a = 0; m_row_a = '0; m_bank_a = sel;
        end
    endtask

    task automatic wait_idle_a(input string tag);
        int t = 0;
        while (busy_a && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (busy_a) check(tag, 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic full_load_a(input logic sel, input logic [7:0] base, input logic [7:0] b, input int gap);
        pulse_start_a(sel, 1'b1);
        for (int i = 0; i < NR_A * NC_A; i++) send_a(base + 8'(i), 1'b0, gap);
        send_a(b, 1'b1, gap);
        wait_idle_a("a_idle_timeout");
    endtask

    // Monitor for the small instance: write latency, row/bias scoreboard, pulses.
    int   mon_bidx_a;
    logic pend_a;
    wr_t  e_a;
    always @(negedge clk) begin
        if (!rst_a) begin
            pend_a = 1'b0; mon_bidx_a = 0;
        end else begin
            if (pend_a) check("a_we_latency", 32'(we_a), 32'd1);
            pend_a = 1'b0;
            if (start_a && !busy_a && !done_a) mon_bidx_a = 0;
            else if (if_a.s_valid && if_a.s_ready && mon_bidx_a < NR_A * NC_A) begin
                if (mon_bidx_a % NC_A == NC_A - 1 && !if_a.s_last) pend_a = 1'b1;
                mon_bidx_a++;
            end
            if (we_a) begin
                n_we_a++;
                if (wq_a.size() == 0) check("a_we_unexpected", 32'd1, 32'd0);
                else begin
                    e_a = wq_a.pop_front();
                    check("a_addr", 32'(addr_a), 32'(e_a.addr));
                    check("a_row",  32'(row_a),  32'(e_a.row[23:0]));
                    check("a_bank", 32'(bank_a), 32'(e_a.bank));
                end
            end
            if (bl_a) begin
                n_bl_a++;
                if (bq_a.size() == 0) check("a_bload_unexpected", 32'd1, 32'd0);
                else check("a_bias", 32'(bias_a), 32'(bq_a.pop_front()));
                check("a_done_with_bload", 32'(done_a), 32'd1);
                check("a_busy_at_done", 32'(busy_a), 32'd0);
            end
            if (done_a) n_done_a++;
            if (err_a) begin
                n_err_a++;
                check("a_busy_at_err", 32'(busy_a), 32'd0);
            end
        end
    end

    wr_t e_b;
    always @(negedge clk) begin
        if (rst_b) begin
            if (we_b) begin
                n_we_b++;
                if (wq_b.size() == 0) check("b_we_unexpected", 32'd1, 32'd0);
                else begin
                    e_b = wq_b.pop_front();
                    check("b_addr", 32'(addr_b), 32'(e_b.addr));
                    check("b_row_match", 32'(row_b == e_b.row), 32'd1);
                    check("b_bank", 32'(bank_b), 32'(e_b.bank));
                end
            end
            if (bl_b) begin
                n_bl_b++;
                if (bq_b.size() == 0) check("b_bload_unexpected", 32'd1, 32'd0);
                else check("b_bias", 32'(bias_b), 32'(bq_b.pop_front()));
            end
            if (done_b) n_done_b++;
            if (err_b) n_err_b++;
        end
    end

    int we0, bl0, err0, done0;

    initial begin
        rst_a = 1'b0; start_a = 1'b0; msel_a = '0;
        rst_b = 1'b0; start_b = 1'b0; msel_b = '0;
        if_a.s_valid = 1'b0; if_a.s_data = '0; if_a.s_last = 1'b0;
        if_b.s_valid = 1'b0; if_b.s_data = '0; if_b.s_last = 1'b0;
        m_bidx_a = 0; m_row_a = '0; m_bank_a = 1'b0;
        m_bidx_b = 0; m_row_b = '0; m_bank_b = 1'b0; acc_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy_a), 32'd0);
        check("rst_ready",  32'(if_a.s_ready), 32'd0);
        check("rst_we",     32'(we_a), 32'd0);
        check("rst_bload",  32'(bl_a), 32'd0);
        check("rst_done",   32'(done_a), 32'd0);
        check("rst_err",    32'(err_a), 32'd0);
        check("rst_bank",   32'(bank_a), 32'd0);
        check("rst_bias",   32'(bias_a), 32'd0);
        check("rst_row",    32'(row_a), 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;

        // Test 1: continuous beats into bank 1
        full_load_a(1'b1, 8'h01, 8'h7F, 0);
        check("t1_bank", 32'(bank_a), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t1_bias_held", 32'(bias_a), 32'h7F);

        // Test 2: same load with ~30% idle cycles
        full_load_a(1'b1, 8'h01, 8'h7F, 30);

        // Test 3: s_last on beat 4 aborts the load
        we0 = n_we_a; bl0 = n_bl_a; err0 = n_err_a; done0 = n_done_a;
        pulse_start_a(1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) send_a(8'(i), 1'b0, 0);
        send_a(8'h04, 1'b1, 0);
        wait_idle_a("t3_idle_timeout");
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_after_err", 32'(if_a.s_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("t3_writes", 32'(n_we_a - we0), 32'd1);
        check("t3_no_bload", 32'(n_bl_a - bl0), 32'd0);
        check("t3_no_done", 32'(n_done_a - done0), 32'd0);
        check("t3_err", 32'(n_err_a - err0), 32'd1);

        // Test 4: reset after beat 5, then a fresh load into bank 0
        err0 = n_err_a; done0 = n_done_a;
        pulse_start_a(1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b0, 0);
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_rst_busy", 32'(busy_a), 32'd0);
        check("t4_rst_bank", 32'(bank_a), 32'd0);
        check("t4_rst_ready", 32'(if_a.s_ready), 32'd0);
        check("t4_rst_bias", 32'(bias_a), 32'd0);
        rst_a = 1'b1;
        @(posedge clk); #1;
        check("t4_silent_abort", 32'((n_err_a - err0) + (n_done_a - done0)), 32'd0);
        full_load_a(1'b0, 8'h11, 8'h22, 0);
        check("t4_bank", 32'(bank_a), 32'd0);

        // Test 5: s_valid in IDLE and start while busy are both ignored
        if_a.s_valid = 1'b1; if_a.s_data = 8'hAA; if_a.s_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_ready_idle", 32'(if_a.s_ready), 32'd0);
            @(posedge clk); #1;
        end
        if_a.s_valid = 1'b0;
        done0 = n_done_a;
        pulse_start_a(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_a(8'h31 + 8'(i), 1'b0, 0);
        pulse_start_a(1'b0, 1'b0);
        for (int i = 3; i < 6; i++) send_a(8'h31 + 8'(i), 1'b0, 0);
        send_a(8'h5A, 1'b1, 0);
        wait_idle_a("t5_idle_timeout");
        check("t5_done", 32'(n_done_a - done0), 32'd1);
        check("t5_bank", 32'(bank_a), 32'd1);

        check("a_we_total", 32'(n_we_a), 32'(exp_we_a));
        check("a_bload_total", 32'(n_bl_a), 32'(exp_bl_a));
        check("a_done_total", 32'(n_done_a), 32'(exp_bl_a));
        check("a_err_total", 32'(n_err_a), 32'(exp_err_a));
        check("a_wq_empty", 32'(wq_a.size()), 32'd0);

        // Test 6: default parameters, full 3781-beat load into bank 1
        start_b = 1'b1; msel_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; m_bidx_b = 0; m_row_b = '0; m_bank_b = 1'b1;
        for (int i = 0; i < NR_B * NC_B; i++) send_b(20'(i * 37 + 5), 1'b0);
        send_b(20'hABCDE, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("b_beats", 32'(acc_b), 32'd3781);
        check("b_writes", 32'(n_we_b), 32'(NR_B));
        check("b_bloads", 32'(n_bl_b), 32'd1);
        check("b_done", 32'(n_done_b), 32'd1);
        check("b_err", 32'(n_err_b), 32'd0);
        check("b_busy", 32'(busy_b), 32'd0);
        check("b_bias_held", 32'(bias_b), 32'hABCDE);
        check("b_wq_empty", 32'(wq_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
